// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter for the processor-side device bus.
// Single-beat req/ack transactions with a bounded burst allowance per master.
module dev_bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_rd,
    output logic [31:0] PrAddr,
    output logic [31:0] PrWD,
    output logic        PrWe,
    input  logic [31:0] PrRD,
    output logic [1:0]  arb_owner
);

    localparam int unsigned RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [31:0]      rd_q, rd_d;
    logic             winner;

    // State and arbitration history registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            run_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            run_q   <= run_d;
            rd_q    <= rd_d;
        end
    end

    // Next-state, winner selection and burst run accounting
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        run_d   = run_q;
        rd_d    = rd_q;
        winner  = 1'b0;

        // Under contention the previous owner keeps the bus until its burst allowance is used up
        if (m0_req && m1_req) begin
            winner = (run_q < RUN_MAX) ? last_q : ~last_q;
        end else begin
            winner = m1_req;
        end

        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = BEAT;
                    owner_d = winner;
                    if (winner == last_q) begin
                        run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
                    end else begin
                        run_d  = RUN_W'(1);
                        last_d = winner;
                    end
                end
            end
            BEAT: begin
                rd_d    = PrRD;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus is driven only during BEAT; address 0 decodes to no device otherwise
    always_comb begin
        PrAddr    = '0;
        PrWD      = '0;
        PrWe      = 1'b0;
        arb_owner = 2'b00;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        if (state_q == BEAT) begin
            PrAddr = owner_q ? m1_addr : m0_addr;
            PrWD   = owner_q ? m1_wd   : m0_wd;
            PrWe   = owner_q ? m1_we   : m0_we;
        end
        if (state_q == BEAT || state_q == ACK) begin
            arb_owner = owner_q ? 2'b10 : 2'b01;
        end
        if (state_q == ACK) begin
            m0_ack = ~owner_q;
            m1_ack = owner_q;
        end
    end

    assign m0_rd = rd_q;
    assign m1_rd = rd_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Randomized bench for dev_bus_arbiter against a transaction-timestamp reference model.
module tb_dev_bus_arbiter;

    localparam int unsigned MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req  [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic        we   [2];
    logic        ack0, ack1;
    logic [31:0] rd0, rd1;
    logic [31:0] PrAddr, PrWD, PrRD;
    logic        PrWe;
    logic [1:0]  arb_owner;

    always #5 clk = ~clk;

    dev_bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_addr(addr[0]), .m0_wd(wd[0]), .m0_we(we[0]),
        .m0_ack(ack0), .m0_rd(rd0),
        .m1_req(req[1]), .m1_addr(addr[1]), .m1_wd(wd[1]), .m1_we(we[1]),
        .m1_ack(ack1), .m1_rd(rd1),
        .PrAddr(PrAddr), .PrWD(PrWD), .PrWe(PrWe), .PrRD(PrRD),
        .arb_owner(arb_owner)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each grant is a timestamped transaction (bus cycle, ack cycle, next free cycle)
    int          cyc = 0;
    int          beat_cyc = -1;
    int          ack_cyc = -1;
    int          free_at = 0;
    bit          b_owner = 1'b0;
    bit          m_last = 1'b0;
    int          m_run = 0;
    logic [31:0] rd_exp = '0;
    bit          in_rst = 1'b0;
    int          grant_log[$];

    int          pend[2] = '{0, 0};
    int          ack_cnt[2] = '{0, 0};
    logic [31:0] last_rd[2];
    bit          rand_rd = 1'b1;
    bit          rand_arrive = 1'b0;
    bit          rand_rst = 1'b0;
    bit          rst_on_m1_beat = 1'b0;
    int          rst_hold = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic next_beat(input int i);
        addr[i] = {16'h0000, 16'($urandom_range(16'h7F00, 16'h7FFC))};
        wd[i]   = $urandom;
        we[i]   = 1'($urandom_range(0, 1));
    endtask

    task automatic arm(input int i, input int n);
        pend[i] = n;
        next_beat(i);
        req[i] = 1'b1;
    endtask

    // Decide, from the inputs of the current cycle, what the arbiter does at the coming edge
    task automatic predict();
        bit win;
        if (!reset) begin
            beat_cyc = -1;
            ack_cyc  = -1;
            free_at  = cyc + 1;
            m_last   = 1'b0;
            m_run    = 0;
            rd_exp   = '0;
            in_rst   = 1'b1;
        end else begin
            in_rst = 1'b0;
            if (beat_cyc == cyc) rd_exp = PrRD;
            if (cyc >= free_at && (req[0] || req[1])) begin
                if (req[0] && req[1]) win = (m_run < int'(MAX_BURST)) ? m_last : !m_last;
                else                  win = req[1];
                if (win == m_last) begin
                    m_run = (m_run + 1 > int'(MAX_BURST)) ? int'(MAX_BURST) : m_run + 1;
                end else begin
                    m_run  = 1;
                    m_last = win;
                end
                b_owner  = win;
                beat_cyc = cyc + 1;
                ack_cyc  = cyc + 2;
                free_at  = cyc + 3;
                grant_log.push_back(int'(win));
            end
        end
    endtask

    task automatic check_cycle();
        bit bus, ak;
        int o;
        bus = (beat_cyc == cyc);
        ak  = (ack_cyc == cyc);
        o   = int'(b_owner);
        check("praddr", PrAddr, bus ? addr[o] : 32'h0);
        check("prwd",   PrWD,   bus ? wd[o]   : 32'h0);
        check("prwe",   32'(PrWe), bus ? 32'(we[o]) : 32'h0);
        check("arb_owner", 32'(arb_owner), (bus || ak) ? (b_owner ? 32'h2 : 32'h1) : 32'h0);
        check("m0_ack", 32'(ack0), 32'(ak && !b_owner));
        check("m1_ack", 32'(ack1), 32'(ak && b_owner));
        if (ak) begin
            check("m0_rd", rd0, rd_exp);
            check("m1_rd", rd1, rd_exp);
        end
        if (in_rst) begin
            check("m0_rd_rst", rd0, 32'h0);
            check("m1_rd_rst", rd1, 32'h0);
        end
    endtask

    // Master and environment reactions, driven for the cycle just entered
    task automatic react();
        if (ack0) begin
            ack_cnt[0]++;
            last_rd[0] = rd0;
            if (pend[0] > 0) pend[0]--;
            next_beat(0);
        end
        if (ack1) begin
            ack_cnt[1]++;
            last_rd[1] = rd1;
            if (pend[1] > 0) pend[1]--;
            next_beat(1);
        end
        if (rand_arrive) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 3) == 0) begin
                    pend[i] = $urandom_range(1, 6);
                    next_beat(i);
                end
            end
        end
        if (rst_hold > 0) begin
            reset = 1'b0;
            rst_hold--;
        end else if (rst_on_m1_beat && beat_cyc == cyc && b_owner) begin
            reset = 1'b0;
            rst_on_m1_beat = 1'b0;
        end else if (rand_rst && $urandom_range(0, 59) == 0) begin
            reset = 1'b0;
        end else begin
            reset = 1'b1;
        end
        if (rand_rd) PrRD = $urandom;
        req[0] = (pend[0] > 0);
        req[1] = (pend[1] > 0);
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
        react();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((pend[0] > 0 || pend[1] > 0 || cyc < free_at) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) check("drain_timeout", 32'(k), 32'(budget - 1));
    endtask

    initial begin
        int base, c1, k;
        reset = 1'b0;
        PrRD  = '0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; addr[i] = '0; wd[i] = '0; we[i] = 1'b0; last_rd[i] = '0;
        end

        // Reset with both requesting, then sustained contention for 24 beats
        arm(0, 12);
        arm(1, 12);
        rst_hold = 1;
        drain(200);
        check("contention_count", 32'(grant_log.size()), 32'd24);
        for (int i = 0; i < 24 && i < grant_log.size(); i++)
            check("contention_order", 32'(grant_log[i]), 32'((i / 4) % 2));

        // Directed m0 read
        rand_rd = 1'b0;
        PrRD = 32'h0000_00A5;
        arm(0, 1);
        addr[0] = 32'h0000_7F20;
        we[0]   = 1'b0;
        drain(20);
        check("m0_read_data", last_rd[0], 32'h0000_00A5);
        rand_rd = 1'b1;

        // Directed m1 write
        c1 = ack_cnt[1];
        arm(1, 1);
        addr[1] = 32'h0000_7F04;
        wd[1]   = 32'h0000_1234;
        we[1]   = 1'b1;
        drain(20);
        check("m1_write_acks", 32'(ack_cnt[1] - c1), 32'd1);

        // Lone m1 requester for 10 beats, then m0 joins while m1 still requests
        base = grant_log.size();
        arm(1, 11);
        k = 0;
        while (pend[1] > 1 && k < 100) begin
            step();
            k++;
        end
        arm(0, 1);
        drain(40);
        check("lone_count", 32'(grant_log.size() - base), 32'd12);
        for (int i = 0; i < 10 && base + i < grant_log.size(); i++)
            check("lone_m1", 32'(grant_log[base + i]), 32'd1);
        if (base + 10 < grant_log.size())
            check("m0_after_saturation", 32'(grant_log[base + 10]), 32'd0);

        // Reset during an m1 BEAT: the beat is dropped and m1 re-requests
        c1 = ack_cnt[1];
        rst_on_m1_beat = 1'b1;
        arm(1, 1);
        drain(40);
        check("m1_rereq_acks", 32'(ack_cnt[1] - c1), 32'd1);
        check("rst_beat_used", 32'(rst_on_m1_beat), 32'd0);

        // Random traffic with occasional resets
        rand_arrive = 1'b1;
        rand_rst    = 1'b1;
        for (int i = 0; i < 900; i++) step();
        rand_arrive = 1'b0;
        rand_rst    = 1'b0;
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
